// File: rtl/cordic_result_collector.sv
// Collects finished CORDIC results: acknowledges the CORDIC FSM once per result and
// buffers {op, data} in a small FIFO drained by a valid/ready consumer.
module cordic_result_collector #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ready_CORDIC,
  input  logic [W-1:0]                 data_output,
  input  logic                         operation,
  output logic                         ACK_FSM_CORDIC,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_data,
  output logic                         out_op,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         full,
  output logic [CNT_W-1:0]             total_count,
  output logic [1:0]                   dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_t;

  // Handshake: out_valid marks a live head entry; a read happens on every rising
  // edge where out_valid && out_ready, and head data holds until that edge.
  state_t           state_q;
  logic             ack_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [W:0]       mem_q [DEPTH];
  logic             full_w;
  logic             wr_en;
  logic             rd_en;

  // Full is taken from the registered count, so a read on the same edge cannot
  // open a slot for a write; the capture slips to the next edge.
  always_comb begin
    full_w   = (count_q == CW'(DEPTH));
    wr_en    = (state_q == S_IDLE) && ready_CORDIC && !full_w;
    rd_en    = (count_q != '0) && out_ready;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    total_d  = wr_en ? total_q + 1'b1 : total_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // WAIT_LOW guards against re-capturing a ready level that lingers after ACK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_en) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end
        end
        S_ACK: begin
          state_q <= S_WAIT_LOW;
          ack_q   <= 1'b0;
        end
        S_WAIT_LOW: begin
          if (!ready_CORDIC) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      total_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      total_q  <= total_d;
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {operation, data_output};
  end

  assign ACK_FSM_CORDIC = ack_q;
  assign out_valid      = (count_q != '0);
  assign out_data       = mem_q[rd_ptr_q][W-1:0];
  assign out_op         = mem_q[rd_ptr_q][W];
  assign fifo_count     = count_q;
  assign full           = full_w;
  assign total_count    = total_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_cordic_result_collector.sv
// Bench for cordic_result_collector: directed scenarios plus random traffic, all
// checked against a queue-based model of the capture/FIFO rules.
module tb_cordic_result_collector;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ready_CORDIC = 1'b0;
  logic [W-1:0]  data_output = '0;
  logic          operation = 1'b0;
  logic          out_ready = 1'b0;
  logic          ACK_FSM_CORDIC, out_valid, out_op, full;
  logic [W-1:0]  out_data;
  logic [CW-1:0] fifo_count;
  logic [15:0]   total_count;
  logic [1:0]    dbg_state;

  // Second instance with a narrow total counter so its wrap is reachable quickly.
  logic          w_ready = 1'b0;
  logic [W-1:0]  w_data = '0;
  logic          w_ack, w_valid, w_op, w_full;
  logic [W-1:0]  w_out_data;
  logic [CW-1:0] w_count;
  logic [7:0]    w_total;
  logic [1:0]    w_dbg;

  always #5 clk = ~clk;

  cordic_result_collector #(.W(W), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .ready_CORDIC(ready_CORDIC), .data_output(data_output),
    .operation(operation), .ACK_FSM_CORDIC(ACK_FSM_CORDIC), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_op(out_op), .fifo_count(fifo_count),
    .full(full), .total_count(total_count), .dbg_state_o(dbg_state)
  );

  cordic_result_collector #(.W(W), .DEPTH(DEPTH), .CNT_W(8)) u_dut_wrap (
    .clk(clk), .reset(reset), .ready_CORDIC(w_ready), .data_output(w_data),
    .operation(1'b0), .ACK_FSM_CORDIC(w_ack), .out_valid(w_valid),
    .out_ready(1'b1), .out_data(w_out_data), .out_op(w_op), .fifo_count(w_count),
    .full(w_full), .total_count(w_total), .dbg_state_o(w_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_ack    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model / scoreboard ----------------
  // A result is taken when ready is high, the FIFO has room, no ACK is in flight,
  // and ready has been seen low at some edge since the previous ACK cycle.
  logic [W:0]  exp_q[$];
  logic        exp_ack   = 1'b0;
  logic        need_low  = 1'b0;
  logic [15:0] exp_total = '0;
  logic        m_cap;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_ack   = 1'b0;
      need_low  = 1'b0;
      exp_total = '0;
    end else begin
      m_cap = !exp_ack && !need_low && ready_CORDIC && (exp_q.size() < DEPTH);
      if (!exp_ack && need_low && !ready_CORDIC) need_low = 1'b0;
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (m_cap) begin
        exp_q.push_back({operation, data_output});
        exp_total = exp_total + 16'd1;
        need_low  = 1'b1;
      end
      exp_ack = m_cap;
    end
  end

  always @(negedge clk) begin
    if (ACK_FSM_CORDIC) n_ack++;
    check("ack", ACK_FSM_CORDIC, exp_ack);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("fifo_count", fifo_count, exp_q.size());
    check("full", full, exp_q.size() == DEPTH);
    check("total_count", total_count, exp_total);
    if (exp_q.size() != 0) begin
      check("out_data", out_data, exp_q[0][W-1:0]);
      check("out_op", out_op, exp_q[0][W]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b0; ready_CORDIC = 1'b0; out_ready = 1'b0; w_ready = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
  endtask

  // Waits (on negedges) for the ACK pulse; cnt is the number of negedges waited.
  task automatic wait_ack(input int max_cyc, output int cnt);
    logic got;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < max_cyc) begin
      @(negedge clk);
      cnt++;
      if (ACK_FSM_CORDIC) got = 1'b1;
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
  endtask

  // Presents one result; rd also pulses out_ready on the capture edge.
  task automatic send(input logic [W-1:0] d, input logic o, input int linger,
                      input logic rd, output int lat);
    logic got;
    @(posedge clk); #1;
    ready_CORDIC = 1'b1; data_output = d; operation = o;
    if (rd) out_ready = 1'b1;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (ACK_FSM_CORDIC) got = 1'b1;
      if (rd && lat == 1) begin
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
    repeat (linger + 1) @(posedge clk);
    #1;
    ready_CORDIC = 1'b0;
    data_output  = $urandom;
  endtask

  // ---------------- main sequence ----------------
  int  lat;
  int  a0;
  bit  rnd_done;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", ACK_FSM_CORDIC, 0);
    check("rst_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", full, 0);
    check("rst_total", total_count, 0);
    @(negedge clk); #2;
    reset = 1'b1;

    // Single result
    a0 = n_ack;
    send(32'h3F80_0000, 1'b1, 1, 1'b0, lat);
    check("t1_ack_latency", lat, 2);
    repeat (2) @(negedge clk);
    check("t1_ack_pulses", n_ack - a0, 1);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 32'h3F80_0000);
    check("t1_op", out_op, 1);
    check("t1_count", fifo_count, 1);
    check("t1_total", total_count, 1);

    // Lingering ready
    do_reset();
    a0 = n_ack;
    send(32'h1234_5678, 1'b0, 2, 1'b0, lat);
    repeat (4) @(negedge clk);
    check("t2_ack_pulses", n_ack - a0, 1);
    check("t2_count", fifo_count, 1);

    // Fill and stall
    do_reset();
    a0 = n_ack;
    for (int i = 1; i <= 4; i++) send(W'(i), 1'(i), 0, 1'b0, lat);
    check("t3_acks", n_ack - a0, 4);
    check("t3_full", full, 1);
    @(posedge clk); #1;
    ready_CORDIC = 1'b1; data_output = 32'h5; operation = 1'b1;
    a0 = n_ack;
    repeat (6) @(negedge clk);
    check("t3_no_ack_full", n_ack - a0, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t3_head_after_read", out_data, 32'h2);
    wait_ack(20, lat);
    check("t3_ack_after_free", lat, 2);
    @(posedge clk); #1;
    ready_CORDIC = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_drain_order", out_data, k + 2);
    end
    @(negedge clk);
    check("t3_drained", out_valid, 0);
    #1 out_ready = 1'b0;

    // Concurrent read/write with pointer wrap
    do_reset();
    send(32'hA0, 1'b0, 0, 1'b0, lat);
    send(32'hA1, 1'b1, 0, 1'b0, lat);
    for (int i = 0; i < 6; i++) begin
      send(32'hB0 + W'(i), 1'(i), 0, 1'b1, lat);
      @(negedge clk);
      check("t4_count_steady", fifo_count, 2);
    end
    check("t4_total", total_count, 8);
    check("t4_head", out_data, 32'hB4);

    // Reset mid-handshake
    do_reset();
    for (int i = 0; i < 3; i++) send(32'hC0 + W'(i), 1'b0, 0, 1'b0, lat);
    @(posedge clk); #1;
    ready_CORDIC = 1'b1; data_output = 32'hBEEF; operation = 1'b0;
    wait_ack(20, lat);
    #1 reset = 1'b0;
    #1;
    check("t5_ack_drop", ACK_FSM_CORDIC, 0);
    check("t5_count", fifo_count, 0);
    check("t5_valid", out_valid, 0);
    check("t5_total", total_count, 0);
    @(negedge clk); #2;
    reset = 1'b1;
    wait_ack(20, lat);
    check("t5_recapture_total", total_count, 1);
    check("t5_recapture_data", out_data, 32'hBEEF);
    @(posedge clk); #1;
    ready_CORDIC = 1'b0;

    // Random traffic
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          send($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, lat);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b0;
    check("rnd_total", total_count, exp_total);

    // Total counter wrap (8-bit instance)
    do_reset();
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      w_ready = 1'b1; w_data = W'(i);
      lat = 0;
      while (!w_ack && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      if (!w_ack) check("wrap_ack_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      w_ready = 1'b0;
      if (i == 254) check("wrap_total_ff", w_total, 8'hFF);
    end
    repeat (3) @(negedge clk);
    check("wrap_total_zero", w_total, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    check("global_timeout", 64'd0, 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
